// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory blocks: memory geometry
// defaults, the loader FSM encoding and the little-endian byte-lane helper.
package imem_loader_pkg;

  localparam int MEM_SIZE_DEF = 4096;
  localparam int ADDR_W_DEF   = 12;
  localparam int WORD_BYTES   = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_FINISH  = 2'd3
  } loader_state_t;

  // Byte k lands in bits [8k+7:8k], matching the fetch order of the memory.
  function automatic logic [31:0] put_byte(input logic [31:0] word,
                                           input logic [1:0]  lane,
                                           input logic [7:0]  data);
    logic [31:0] result;
    result = word;
    result[8*lane +: 8] = data;
    return result;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and word-write output of the loader. The slave modport is
// the loader itself; the master modport is the stream source / memory side.
interface imem_loader_if #(
  parameter int ADDR_W = imem_loader_pkg::ADDR_W_DEF
) ();

  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  modport master (
    output s_valid,
    output s_data,
    input  s_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

endinterface

// File: rtl/imem_loader.sv
// Loads a little-endian byte stream into instruction memory one 32-bit word
// at a time: four accepted bytes, then one write strobe.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MEM_SIZE = MEM_SIZE_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-2:0] len_words,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-2:0] word_count,
  imem_loader_if.slave      bus
);

  localparam logic [ADDR_W+1:0] MEM_LIMIT = (ADDR_W+2)'(MEM_SIZE);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(WORD_BYTES);
  localparam logic [ADDR_W-2:0] CNT_ONE   = (ADDR_W-1)'(1);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       word_q, word_d;
  logic [1:0]        idx_q, idx_d;
  logic [ADDR_W-2:0] count_q, count_d;
  logic [ADDR_W-2:0] len_q, len_d;
  logic              error_q, error_d;

  logic [ADDR_W+1:0] end_addr;
  logic              range_bad;
  logic [ADDR_W-2:0] count_inc;

  // End address is computed two bits wider so 4*len_words cannot wrap.
  always_comb begin
    end_addr  = {2'b00, base_addr} + {1'b0, len_words, 2'b00};
    range_bad = (base_addr[1:0] != 2'b00) || (end_addr > MEM_LIMIT);
    count_inc = count_q + CNT_ONE;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    word_d  = word_q;
    idx_d   = idx_q;
    count_d = count_q;
    len_d   = len_q;
    error_d = error_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          error_d = 1'b0;
          count_d = '0;
          len_d   = len_words;
          addr_d  = base_addr;
          idx_d   = 2'd0;
          word_d  = '0;
          if (range_bad) begin
            error_d = 1'b1;
            state_d = ST_FINISH;
          end else if (len_words == '0) begin
            state_d = ST_FINISH;
          end else begin
            state_d = ST_COLLECT;
          end
        end
      end

      ST_COLLECT: begin
        if (bus.s_valid) begin
          word_d = put_byte(word_q, idx_q, bus.s_data);
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = ST_WRITE;
          end
        end
      end

      // The write strobe is this single cycle; bookkeeping advances on exit.
      ST_WRITE: begin
        addr_d  = addr_q + ADDR_STEP;
        count_d = count_inc;
        idx_d   = 2'd0;
        if (count_inc == len_q) begin
          state_d = ST_FINISH;
        end else begin
          state_d = ST_COLLECT;
        end
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Reset clears the partially assembled word as well, so nothing stale
  // can ever reach the memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      word_q  <= '0;
      idx_q   <= 2'd0;
      count_q <= '0;
      len_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      len_q   <= len_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    bus.s_ready   = (state_q == ST_COLLECT);
    bus.mem_we    = (state_q == ST_WRITE);
    bus.mem_addr  = addr_q;
    bus.mem_wdata = word_q;
    busy          = (state_q != ST_IDLE);
    done          = (state_q == ST_FINISH);
    error         = error_q;
    word_count    = count_q;
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: writes are captured by a
// monitor and compared against hand-computed address/data pairs.
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [11:0] base_addr;
  logic [10:0] len_words;
  logic        busy;
  logic        done;
  logic        error;
  logic [10:0] word_count;

  int checks;
  int errors;
  int done_cnt;
  logic [11:0] wr_addr[$];
  logic [31:0] wr_data[$];

  imem_loader_if #(.ADDR_W(12)) bus ();

  imem_loader #(.MEM_SIZE(4096), .ADDR_W(12)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .len_words  (len_words),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .word_count (word_count),
    .bus        (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.mem_we) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_wdata);
    end
    if (done) done_cnt++;
  end

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    done_cnt = 0;
  endtask

  // Called at a negedge; returns at the negedge after the start cycle.
  task automatic pulse_start(input logic [11:0] base, input logic [10:0] len);
    start = 1'b1; base_addr = base; len_words = len;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.s_valid = 1'b1; bus.s_data = b;
    while (!bus.s_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      errors++;
      $display("FAIL send_byte timeout: s_ready=%0b required 1", bus.s_ready);
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL wait_idle timeout: busy=%0b required 0", busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks += 8;
    if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready got %0b want 0", bus.s_ready); end
    if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got %0b want 0", bus.mem_we); end
    if (bus.mem_addr !== 12'h000) begin errors++; $display("FAIL rst_mem_addr got %h want 000", bus.mem_addr); end
    if (bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata got %h want 0", bus.mem_wdata); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b want 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %0b want 0", done); end
    if (error !== 1'b0) begin errors++; $display("FAIL rst_error got %0b want 0", error); end
    if (word_count !== 11'd0) begin errors++; $display("FAIL rst_word_count got %0d want 0", word_count); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] bytes [8];
    bytes = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    clear_log();
    pulse_start(12'h000, 11'd2);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %0b want 1", busy); end
    for (int i = 0; i < 8; i++) send_byte(bytes[i]);
    wait_idle();
    checks += 5;
    if (wr_addr.size() !== 2) begin
      errors++; $display("FAIL basic_nwrites got %0d want 2", wr_addr.size());
    end else begin
      if (wr_addr[0] !== 12'h000 || wr_data[0] !== 32'h00000013) begin
        errors++; $display("FAIL basic_w0 got %h/%h want 000/00000013", wr_addr[0], wr_data[0]);
      end
      if (wr_addr[1] !== 12'h004 || wr_data[1] !== 32'h00100093) begin
        errors++; $display("FAIL basic_w1 got %h/%h want 004/00100093", wr_addr[1], wr_data[1]);
      end
    end
    if (word_count !== 11'd2) begin errors++; $display("FAIL basic_word_count got %0d want 2", word_count); end
    if (done_cnt !== 1) begin errors++; $display("FAIL basic_done got %0d pulses want 1", done_cnt); end
    if (error !== 1'b0) begin errors++; $display("FAIL basic_error got %0b want 0", error); end
  endtask

  task automatic test_misaligned();
    clear_log();
    pulse_start(12'h002, 11'd1);
    checks += 2;
    if (done !== 1'b1) begin errors++; $display("FAIL misal_done got %0b want 1", done); end
    if (error !== 1'b1) begin errors++; $display("FAIL misal_error got %0b want 1", error); end
    @(negedge clk);
    checks += 4;
    if (done !== 1'b0) begin errors++; $display("FAIL misal_done_drop got %0b want 0", done); end
    if (busy !== 1'b0) begin errors++; $display("FAIL misal_busy got %0b want 0", busy); end
    if (error !== 1'b1) begin errors++; $display("FAIL misal_sticky got %0b want 1", error); end
    if (wr_addr.size() !== 0) begin errors++; $display("FAIL misal_nwrites got %0d want 0", wr_addr.size()); end
  endtask

  task automatic test_top_edge();
    clear_log();
    pulse_start(12'hFFC, 11'd1);
    checks++;
    if (error !== 1'b0) begin errors++; $display("FAIL top_error_clr got %0b want 0", error); end
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    wait_idle();
    checks += 2;
    if (wr_addr.size() !== 1) begin
      errors++; $display("FAIL top_nwrites got %0d want 1", wr_addr.size());
    end else if (wr_addr[0] !== 12'hFFC || wr_data[0] !== 32'h44332211) begin
      errors++; $display("FAIL top_w0 got %h/%h want FFC/44332211", wr_addr[0], wr_data[0]);
    end
    if (done_cnt !== 1) begin errors++; $display("FAIL top_done got %0d want 1", done_cnt); end
    clear_log();
    pulse_start(12'hFFC, 11'd2);
    checks++;
    if (error !== 1'b1) begin errors++; $display("FAIL top_overflow_error got %0b want 1", error); end
    wait_idle();
    checks += 2;
    if (wr_addr.size() !== 0) begin errors++; $display("FAIL top_overflow_nwrites got %0d want 0", wr_addr.size()); end
    if (word_count !== 11'd0) begin errors++; $display("FAIL top_overflow_count got %0d want 0", word_count); end
  endtask

  task automatic test_len_zero();
    clear_log();
    pulse_start(12'h100, 11'd0);
    checks += 3;
    if (done !== 1'b1) begin errors++; $display("FAIL len0_done got %0b want 1", done); end
    if (error !== 1'b0) begin errors++; $display("FAIL len0_error got %0b want 0", error); end
    if (word_count !== 11'd0) begin errors++; $display("FAIL len0_count got %0d want 0", word_count); end
    // This start lands in the FINISH cycle and must be ignored.
    pulse_start(12'h002, 11'd1);
    checks += 4;
    if (busy !== 1'b0) begin errors++; $display("FAIL len0_ignore_busy got %0b want 0", busy); end
    if (error !== 1'b0) begin errors++; $display("FAIL len0_ignore_error got %0b want 0", error); end
    if (done_cnt !== 1) begin errors++; $display("FAIL len0_done_cnt got %0d want 1", done_cnt); end
    if (wr_addr.size() !== 0) begin errors++; $display("FAIL len0_nwrites got %0d want 0", wr_addr.size()); end
  endtask

  task automatic test_stall();
    logic [7:0] bytes [4];
    bytes = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    clear_log();
    pulse_start(12'h040, 11'd1);
    pulse_start(12'h003, 11'd5);
    for (int i = 0; i < 4; i++) begin
      send_byte(bytes[i]);
      @(negedge clk);
    end
    wait_idle();
    checks += 4;
    if (wr_addr.size() !== 1) begin
      errors++; $display("FAIL stall_nwrites got %0d want 1", wr_addr.size());
    end else if (wr_addr[0] !== 12'h040 || wr_data[0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL stall_w0 got %h/%h want 040/DEADBEEF", wr_addr[0], wr_data[0]);
    end
    if (error !== 1'b0) begin errors++; $display("FAIL stall_error got %0b want 0", error); end
    if (word_count !== 11'd1) begin errors++; $display("FAIL stall_count got %0d want 1", word_count); end
    if (done_cnt !== 1) begin errors++; $display("FAIL stall_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    clear_log();
    pulse_start(12'h080, 11'd1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    rst_n = 1'b0;
    #1;
    checks += 5;
    if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %0b want 0", busy); end
    if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL rmid_s_ready got %0b want 0", bus.s_ready); end
    if (bus.mem_addr !== 12'h000) begin errors++; $display("FAIL rmid_mem_addr got %h want 000", bus.mem_addr); end
    if (bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL rmid_mem_wdata got %h want 0", bus.mem_wdata); end
    if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rmid_mem_we got %0b want 0", bus.mem_we); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (wr_addr.size() !== 0) begin errors++; $display("FAIL rmid_nwrites got %0d want 0", wr_addr.size()); end
    clear_log();
    pulse_start(12'h080, 11'd1);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    wait_idle();
    checks += 2;
    if (wr_addr.size() !== 1) begin
      errors++; $display("FAIL rmid_fresh_nwrites got %0d want 1", wr_addr.size());
    end else if (wr_addr[0] !== 12'h080 || wr_data[0] !== 32'h04030201) begin
      errors++; $display("FAIL rmid_fresh_w0 got %h/%h want 080/04030201", wr_addr[0], wr_data[0]);
    end
    if (word_count !== 11'd1) begin errors++; $display("FAIL rmid_fresh_count got %0d want 1", word_count); end
  endtask

  initial begin
    checks = 0; errors = 0; done_cnt = 0;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; len_words = '0;
    bus.s_valid = 1'b0; bus.s_data = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_misaligned();
    test_top_edge();
    test_len_zero();
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
